// File: rtl/uc_multiciclo_pkg.sv
// uc_pkg
// Shared definitions for the multicycle control unit: the controller state
// encoding, the instruction-class codes found in opcode[5:2] (instruction
// bits [15:12]), and the bundle of control fields produced by the decoder.
// No ports; imported by uc_decode and uc_multiciclo.
package uc_pkg;

    // Controller states; every instruction walks FETCH -> DECODE -> EXEC
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_e;

    // Instruction classes for the non-ALU half of the opcode space
    localparam logic [3:0] OP_LI   = 4'b0000;
    localparam logic [3:0] OP_J    = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_NOP  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0101;

    // Bit of the 4-bit class that marks an ALU instruction (class 1xxx)
    localparam int ALU_CLASS_BIT = 3;

    // Width of the ALU operation field carried in the opcode
    localparam int ALU_W = 3;

    // Control fields for one instruction, as seen during EXEC
    typedef struct packed {
        logic             sInc;
        logic             sInm;
        logic             we3;
        logic             wez;
        logic             pcWe;
        logic [ALU_W-1:0] opAlu;
    } ctrl_t;

endpackage

// File: rtl/uc_multiciclo_decode.sv
// uc_decode
// Purely combinational instruction decoder. Maps the opcode class and the
// zero flag to the control bundle the controller applies during EXEC.
// Ports:
//   opcode_i      instruction bits [15:10] from the IR
//   z_i           zero flag register output
//   ctrl_o        control bundle (sInc, sInm, we3, wez, pcWe, opAlu)
//   is_halt_o     opcode is HALT
//   is_illegal_o  opcode is in the unused class range 0110/0111
module uc_decode
    import uc_pkg::*;
#(
    parameter int OPW             = 6,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic           z_i,
    output ctrl_t          ctrl_o,
    output logic           is_halt_o,
    output logic           is_illegal_o
);

    logic [3:0] opClass;
    logic       unused_low;

    assign opClass = opcode_i[OPW-1 -: 4];

    // The two low opcode bits carry no control meaning
    assign unused_low = ^opcode_i[OPW-5:0];

    // Start from "advance the PC, write nothing" and let each class add its
    // own enables; conditional jumps pick PC+1 when their condition fails.
    always_comb begin
        ctrl_o.sInc  = 1'b1;
        ctrl_o.sInm  = 1'b0;
        ctrl_o.we3   = 1'b0;
        ctrl_o.wez   = 1'b0;
        ctrl_o.pcWe  = 1'b1;
        ctrl_o.opAlu = '0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        if (opClass[ALU_CLASS_BIT]) begin
            ctrl_o.opAlu = opcode_i[OPW-2 -: ALU_W];
            ctrl_o.we3   = 1'b1;
            ctrl_o.wez   = 1'b1;
        end else begin
            case (opClass)
                OP_LI: begin
                    ctrl_o.sInm = 1'b1;
                    ctrl_o.we3  = 1'b1;
                end
                OP_J:    ctrl_o.sInc = 1'b0;
                OP_JZ:   ctrl_o.sInc = ~z_i;
                OP_JNZ:  ctrl_o.sInc = z_i;
                OP_NOP:  ;
                OP_HALT: begin
                    is_halt_o   = 1'b1;
                    ctrl_o.pcWe = 1'b0;
                end
                default: begin
                    is_illegal_o = 1'b1;
                    ctrl_o.pcWe  = ~HALT_ON_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo
// Multicycle control unit for the 16-bit-instruction CPU. Each instruction
// takes exactly three cycles: FETCH (load IR), DECODE (latch control fields),
// EXEC (apply PC / register / flag writes). A level-sensitive run input starts
// execution from IDLE and is checked again only at the end of each EXEC.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   opcode, z, run  IR bits [15:10], zero flag, run request
//   s_inc, s_inm, we3, wez, op_alu, pc_we, ir_we   datapath controls
//   halted, illegal status (illegal is sticky until reset)
// Optional feature, macro UC_RETIRE_CNT_EN: adds output retired[15:0], a
// wrapping count of EXEC cycles that were not illegal instructions.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int OPW             = 6,
    parameter int ALUW            = 3,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            z,
    input  logic            run,
    output logic            s_inc,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [ALUW-1:0] op_alu,
    output logic            pc_we,
    output logic            ir_we,
    output logic            halted,
    output logic            illegal
`ifdef UC_RETIRE_CNT_EN
    ,
    output logic [15:0]     retired
`endif
);

    state_e           state_q;
    logic             sInc_q;
    logic             sInm_q;
    logic             we3_q;
    logic             wez_q;
    logic [ALU_W-1:0] opAlu_q;
    logic             pcWe_q;
    logic             irWe_q;
    logic             halted_q;
    logic             illegal_q;

    ctrl_t            dec;
    logic             decHalt;
    logic             decIllegal;

    uc_decode #(
        .OPW             (OPW),
        .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
    ) u_decode (
        .opcode_i     (opcode),
        .z_i          (z),
        .ctrl_o       (dec),
        .is_halt_o    (decHalt),
        .is_illegal_o (decIllegal)
    );

    // Main sequencer. Every output is a register loaded on the edge that
    // enters the state it belongs to, so the enables line up exactly with
    // FETCH / EXEC. Control fields are latched on the DECODE -> EXEC edge;
    // z cannot change between DECODE and EXEC because the flag only updates
    // on wez at the end of an EXEC, so the value latched is the EXEC value.
    // Outside EXEC the control fields fall back to PC+1 / ALU result / op 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sInc_q    <= 1'b1;
            sInm_q    <= 1'b0;
            we3_q     <= 1'b0;
            wez_q     <= 1'b0;
            opAlu_q   <= '0;
            pcWe_q    <= 1'b0;
            irWe_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            sInc_q  <= 1'b1;
            sInm_q  <= 1'b0;
            we3_q   <= 1'b0;
            wez_q   <= 1'b0;
            opAlu_q <= '0;
            pcWe_q  <= 1'b0;
            irWe_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= FETCH;
                        irWe_q  <= 1'b1;
                    end
                end
                FETCH: state_q <= DECODE;
                DECODE: begin
                    state_q <= EXEC;
                    sInc_q  <= dec.sInc;
                    sInm_q  <= dec.sInm;
                    we3_q   <= dec.we3;
                    wez_q   <= dec.wez;
                    opAlu_q <= dec.opAlu;
                    pcWe_q  <= dec.pcWe;
                    if (decIllegal) begin
                        illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (decHalt || (decIllegal && HALT_ON_ILLEGAL)) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (run) begin
                        state_q <= FETCH;
                        irWe_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HALT: begin
                    if (!run) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_inc   = sInc_q;
    assign s_inm   = sInm_q;
    assign we3     = we3_q;
    assign wez     = wez_q;
    assign op_alu  = ALUW'(opAlu_q);
    assign pc_we   = pcWe_q;
    assign ir_we   = irWe_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

`ifdef UC_RETIRE_CNT_EN
    logic [15:0] retired_q;
    logic [15:0] retired_d;

    // Count every EXEC that is not an illegal opcode; the IR is stable
    // throughout EXEC so the live decode identifies the instruction.
    always_comb begin
        retired_d = retired_q;
        if (state_q == EXEC && !decIllegal) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Retire counter register, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= 16'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo
// Self-checking bench for uc_multiciclo. Instance A uses HALT_ON_ILLEGAL=0,
// instance B uses HALT_ON_ILLEGAL=1; both share clock, reset and z.
// Expected values come from refModel, which works from instruction semantics
// (class number, jump taken, register/flag written, stops the machine).
module tb_uc_multiciclo;

    // Output vector layout: {ir_we, pc_we, we3, wez, s_inc, s_inm, op_alu[2:0], halted, illegal}
    localparam logic [10:0] EN_MASK = 11'b11110000011;

    logic       clock = 1'b0;
    logic       reset;
    logic       z;
    logic       runA, runB;
    logic [5:0] opcodeA, opcodeB;

    logic       sIncA, sInmA, we3A, wezA, pcWeA, irWeA, haltedA, illegalA;
    logic [2:0] opAluA;
    logic       sIncB, sInmB, we3B, wezB, pcWeB, irWeB, haltedB, illegalB;
    logic [2:0] opAluB;
`ifdef UC_RETIRE_CNT_EN
    logic [15:0] retiredA, retiredB;
`endif

    int         checks = 0;
    int         errors = 0;
    logic       illA = 1'b0;
    logic       illB = 1'b0;
    int         retA = 0;

    uc_multiciclo #(.OPW(6), .ALUW(3), .HALT_ON_ILLEGAL(1'b0)) dutA (
        .clk(clock), .reset(reset), .opcode(opcodeA), .z(z), .run(runA),
        .s_inc(sIncA), .s_inm(sInmA), .we3(we3A), .wez(wezA), .op_alu(opAluA),
        .pc_we(pcWeA), .ir_we(irWeA), .halted(haltedA), .illegal(illegalA)
`ifdef UC_RETIRE_CNT_EN
        , .retired(retiredA)
`endif
    );

    uc_multiciclo #(.OPW(6), .ALUW(3), .HALT_ON_ILLEGAL(1'b1)) dutB (
        .clk(clock), .reset(reset), .opcode(opcodeB), .z(z), .run(runB),
        .s_inc(sIncB), .s_inm(sInmB), .we3(we3B), .wez(wezB), .op_alu(opAluB),
        .pc_we(pcWeB), .ir_we(irWeB), .halted(haltedB), .illegal(illegalB)
`ifdef UC_RETIRE_CNT_EN
        , .retired(retiredB)
`endif
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    function automatic logic [10:0] vec(input logic ir, input logic pc, input logic w3,
                                        input logic wz, input logic si, input logic sm,
                                        input logic [2:0] alu, input logic h, input logic il);
        return {ir, pc, w3, wz, si, sm, alu, h, il};
    endfunction

    function automatic logic [10:0] obsA();
        return {irWeA, pcWeA, we3A, wezA, sIncA, sInmA, opAluA, haltedA, illegalA};
    endfunction

    function automatic logic [10:0] obsB();
        return {irWeB, pcWeB, we3B, wezB, sIncB, sInmB, opAluB, haltedB, illegalB};
    endfunction

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs for one instruction: FETCH, DECODE, EXEC and the cycle after EXEC
    task automatic refModel(input logic [5:0] opc, input logic zv, input logic keep,
                            input logic hoi, input logic illBefore,
                            output logic [10:0] fExp, output logic [10:0] dExp,
                            output logic [10:0] eExp, output logic [10:0] nExp,
                            output logic illAfter, output int retires);
        int   cls;
        logic alu, li, taken, isHalt, isIll, stops;
        cls      = int'(opc) / 4;
        alu      = (cls >= 8);
        li       = (cls == 0);
        taken    = (cls == 1) || (cls == 2 && zv) || (cls == 3 && !zv);
        isHalt   = (cls == 5);
        isIll    = (cls == 6) || (cls == 7);
        stops    = isHalt || (isIll && hoi);
        illAfter = illBefore | isIll;
        fExp = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illBefore);
        dExp = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illBefore);
        eExp = vec(1'b0, !stops, alu || li, alu, !taken, li,
                   alu ? 3'(cls % 8) : 3'd0, 1'b0, illAfter);
        if (stops)
            nExp = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, illAfter);
        else if (keep)
            nExp = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illAfter);
        else
            nExp = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illAfter);
        retires = isIll ? 0 : 1;
    endtask

    // Drive one instruction starting in FETCH; run is set to keep during DECODE
    task automatic runOne(input logic useB, input logic [5:0] opc, input logic zv,
                          input logic keep, output logic [10:0] fObs, output logic [10:0] dObs,
                          output logic [10:0] eObs, output logic [10:0] nObs);
        fObs = useB ? obsB() : obsA();
        if (useB) opcodeB = opc; else opcodeA = opc;
        z = zv;
        step();
        dObs = useB ? obsB() : obsA();
        if (useB) runB = keep; else runA = keep;
        step();
        eObs = useB ? obsB() : obsA();
        step();
        nObs = useB ? obsB() : obsA();
    endtask

    task automatic test_reset();
        logic [10:0] idleV;
        idleV = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        runA = 1'b0; runB = 1'b0; opcodeA = '0; opcodeB = '0; z = 1'b0;
        repeat (3) step();
        checks += 2;
        if (obsA() !== idleV) begin errors++; $display("[TB] FAIL reset_A: got %b expected %b", obsA(), idleV); end
        if (obsB() !== idleV) begin errors++; $display("[TB] FAIL reset_B: got %b expected %b", obsB(), idleV); end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks += 2;
            if (obsA() !== idleV) begin errors++; $display("[TB] FAIL idle_A[%0d]: got %b expected %b", i, obsA(), idleV); end
            if (obsB() !== idleV) begin errors++; $display("[TB] FAIL idle_B[%0d]: got %b expected %b", i, obsB(), idleV); end
        end
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (retiredA !== 16'd0) begin errors++; $display("[TB] FAIL reset_retired: got %0d expected 0", retiredA); end
`endif
    endtask

    // Directed table on instance A: ALU, LI, J, JZ/JNZ with both flag values, illegal, NOP
    task automatic test_instructions();
        logic [5:0]  opT[10];
        logic        zT[10];
        logic [10:0] fO, dO, eO, nO, fE, dE, eE, nE;
        logic        illNext;
        int          r;
        opT = '{6'b100101, 6'b000000, 6'b001000, 6'b001000, 6'b001100,
                6'b001100, 6'b000111, 6'b011000, 6'b011111, 6'b010000};
        zT  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        runA = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            refModel(opT[i], zT[i], (i != 9), 1'b0, illA, fE, dE, eE, nE, illNext, r);
            runOne(1'b0, opT[i], zT[i], (i != 9), fO, dO, eO, nO);
            illA = illNext;
            retA += r;
            checks += 4;
            if ((fO & EN_MASK) !== (fE & EN_MASK)) begin errors++; $display("[TB] FAIL instr_fetch[%0d]: got %b expected %b", i, fO, fE); end
            if ((dO & EN_MASK) !== (dE & EN_MASK)) begin errors++; $display("[TB] FAIL instr_decode[%0d]: got %b expected %b", i, dO, dE); end
            if (eO !== eE) begin errors++; $display("[TB] FAIL instr_exec[%0d] op=%b z=%b: got %b expected %b", i, opT[i], zT[i], eO, eE); end
            if ((nO & EN_MASK) !== (nE & EN_MASK)) begin errors++; $display("[TB] FAIL instr_next[%0d]: got %b expected %b", i, nO, nE); end
`ifdef UC_RETIRE_CNT_EN
            checks++;
            if (retiredA !== 16'(retA)) begin errors++; $display("[TB] FAIL instr_retired[%0d]: got %0d expected %0d", i, retiredA, retA); end
`endif
        end
    endtask

    task automatic test_halt();
        logic [10:0] fO, dO, eO, nO, fE, dE, eE, nE, hE, iE;
        logic        illNext;
        int          r;
        runA = 1'b1;
        step();
        refModel(6'b010100, 1'b0, 1'b1, 1'b0, illA, fE, dE, eE, nE, illNext, r);
        runOne(1'b0, 6'b010100, 1'b0, 1'b1, fO, dO, eO, nO);
        illA = illNext;
        retA += r;
        checks += 3;
        if (eO !== eE) begin errors++; $display("[TB] FAIL halt_exec: got %b expected %b", eO, eE); end
        if ((nO & EN_MASK) !== (nE & EN_MASK)) begin errors++; $display("[TB] FAIL halt_enter: got %b expected %b", nO, nE); end
        if ((dO & EN_MASK) !== (dE & EN_MASK)) begin errors++; $display("[TB] FAIL halt_decode: got %b expected %b", dO, dE); end
        hE = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, illA);
        repeat (2) begin
            step();
            checks++;
            if ((obsA() & EN_MASK) !== (hE & EN_MASK)) begin errors++; $display("[TB] FAIL halt_hold: got %b expected %b", obsA(), hE); end
        end
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (retiredA !== 16'(retA)) begin errors++; $display("[TB] FAIL halt_retired: got %0d expected %0d", retiredA, retA); end
`endif
        runA = 1'b0;
        step();
        iE = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illA);
        checks++;
        if ((obsA() & EN_MASK) !== (iE & EN_MASK)) begin errors++; $display("[TB] FAIL halt_release: got %b expected %b", obsA(), iE); end
    endtask

    // Instance B: illegal opcode must stop the machine with no PC write
    task automatic test_illegal_halt();
        logic [10:0] fO, dO, eO, nO, fE, dE, eE, nE, hE;
        logic        illNext;
        int          r;
        runB = 1'b1;
        step();
        refModel(6'b011000, 1'b0, 1'b1, 1'b1, illB, fE, dE, eE, nE, illNext, r);
        runOne(1'b1, 6'b011000, 1'b0, 1'b1, fO, dO, eO, nO);
        illB = illNext;
        checks += 3;
        if ((fO & EN_MASK) !== (fE & EN_MASK)) begin errors++; $display("[TB] FAIL illhalt_fetch: got %b expected %b", fO, fE); end
        if (eO !== eE) begin errors++; $display("[TB] FAIL illhalt_exec: got %b expected %b", eO, eE); end
        if ((nO & EN_MASK) !== (nE & EN_MASK)) begin errors++; $display("[TB] FAIL illhalt_enter: got %b expected %b", nO, nE); end
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (retiredB !== 16'd0) begin errors++; $display("[TB] FAIL illhalt_retired: got %0d expected 0", retiredB); end
`endif
        runB = 1'b0;
        step();
        hE = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, illB);
        checks++;
        if ((obsB() & EN_MASK) !== (hE & EN_MASK)) begin errors++; $display("[TB] FAIL illhalt_release: got %b expected %b", obsB(), hE); end
    endtask

    // Asynchronous reset in the middle of an ALU EXEC drops every enable at once
    task automatic test_reset_mid_exec();
        logic [10:0] fE, dE, eE, nE, idleV;
        logic        illNext;
        int          r;
        refModel(6'b110010, 1'b0, 1'b1, 1'b0, illA, fE, dE, eE, nE, illNext, r);
        runA = 1'b1;
        step();
        opcodeA = 6'b110010;
        z = 1'b0;
        step();
        step();
        checks++;
        if (obsA() !== eE) begin errors++; $display("[TB] FAIL midreset_exec: got %b expected %b", obsA(), eE); end
        #2;
        reset = 1'b0;
        #1;
        idleV = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        checks += 2;
        if (obsA() !== idleV) begin errors++; $display("[TB] FAIL midreset_A: got %b expected %b", obsA(), idleV); end
        if (obsB() !== idleV) begin errors++; $display("[TB] FAIL midreset_B: got %b expected %b", obsB(), idleV); end
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (retiredA !== 16'd0) begin errors++; $display("[TB] FAIL midreset_retired: got %0d expected 0", retiredA); end
`endif
        runA = 1'b0;
        step();
        reset = 1'b1;
        illA = 1'b0;
        illB = 1'b0;
        retA = 0;
        step();
    endtask

    // Random instruction stream on instance A with random run drops during DECODE
    task automatic test_back_to_back();
        logic [5:0]  opc;
        logic        zv, keep, illNext;
        logic [10:0] fO, dO, eO, nO, fE, dE, eE, nE;
        int          r;
        runA = 1'b1;
        step();
        for (int i = 0; i < 150; i++) begin
            do opc = 6'($urandom); while (opc[5:2] == 4'd5);
            zv   = 1'($urandom);
            keep = ($urandom_range(0, 3) != 0);
            refModel(opc, zv, keep, 1'b0, illA, fE, dE, eE, nE, illNext, r);
            runOne(1'b0, opc, zv, keep, fO, dO, eO, nO);
            illA = illNext;
            retA += r;
            checks += 4;
            if ((fO & EN_MASK) !== (fE & EN_MASK)) begin errors++; $display("[TB] FAIL rand_fetch[%0d]: got %b expected %b", i, fO, fE); end
            if ((dO & EN_MASK) !== (dE & EN_MASK)) begin errors++; $display("[TB] FAIL rand_decode[%0d]: got %b expected %b", i, dO, dE); end
            if (eO !== eE) begin errors++; $display("[TB] FAIL rand_exec[%0d] op=%b z=%b: got %b expected %b", i, opc, zv, eO, eE); end
            if ((nO & EN_MASK) !== (nE & EN_MASK)) begin errors++; $display("[TB] FAIL rand_next[%0d] keep=%b: got %b expected %b", i, keep, nO, nE); end
`ifdef UC_RETIRE_CNT_EN
            checks++;
            if (retiredA !== 16'(retA)) begin errors++; $display("[TB] FAIL rand_retired[%0d]: got %0d expected %0d", i, retiredA, retA); end
`endif
            if (!keep) begin
                repeat ($urandom_range(0, 2)) step();
                runA = 1'b1;
                step();
            end
        end
        runA = 1'b0;
    endtask

    // Safety net so the bench always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        test_reset();
        test_instructions();
        test_halt();
        test_illegal_halt();
        test_reset_mid_exec();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
